mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter in front of a single-port
// fixed-latency memory; port 0 fetches instructions, port 1 reads/writes data.
module mem_arbiter #(
  parameter int LAT         = 1,
  parameter int DEPTH_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [31:0] addr0,
  output logic        ack0,
  output logic        err0,
  output logic [31:0] rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        ack1,
  output logic        err1,
  output logic [31:0] rdata1,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] addr,
  output logic [31:0] wd,
  input  logic [31:0] rd
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  localparam logic [31:0] MAX_ADDR = 32'(DEPTH_BYTES - 4);
  localparam logic [3:0]  LAT_CNT  = 4'(LAT);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_gnt;
  logic        r_last;
  logic        r_we;
  logic        r_err;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;

  logic        w_any;
  logic        w_sel;
  logic        w_req_we;
  logic        w_illegal;
  logic        w_in_access;
  logic        w_last_cycle;
  logic [31:0] w_req_addr;
  logic [31:0] w_req_wdata;

  // r_last resets to port 1 so that port 0 wins the first tie.
  always_comb begin
    w_any = req0 | req1;
    if (req0 && req1) begin
      w_sel = ~r_last;
    end else begin
      w_sel = req1;
    end
    w_req_addr  = w_sel ? addr1 : addr0;
    w_req_we    = w_sel & we1;
    w_req_wdata = w_sel ? wdata1 : 32'd0;
    w_illegal   = (w_req_addr[1:0] != 2'b00) || (w_req_addr > MAX_ADDR);
  end

  assign w_in_access  = (r_state == S_ACCESS);
  assign w_last_cycle = w_in_access && (r_cnt == 4'd1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_next = w_illegal ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (r_cnt == 4'd1) begin
          w_next = S_RESP;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_gnt    <= 1'b0;
      r_last   <= 1'b1;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_rdata0 <= 32'd0;
      r_rdata1 <= 32'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_sel;
            r_last  <= w_sel;
            r_addr  <= w_req_addr;
            r_we    <= w_req_we;
            r_wdata <= w_req_wdata;
            r_err   <= w_illegal;
            r_cnt   <= w_illegal ? 4'd0 : LAT_CNT;
          end
        end
        S_ACCESS: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1 && !r_we) begin
            if (r_gnt) begin
              r_rdata1 <= rd;
            end else begin
              r_rdata0 <= rd;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Strobes and bus values decode from registered state only.
  assign MemRead  = w_in_access & ~r_we;
  assign MemWrite = w_last_cycle & r_we;
  assign addr     = w_in_access ? r_addr : 32'd0;
  assign wd       = w_in_access ? r_wdata : 32'd0;

  assign ack0   = (r_state == S_RESP) && !r_gnt;
  assign ack1   = (r_state == S_RESP) && r_gnt;
  assign err0   = ack0 & r_err;
  assign err1   = ack1 & r_err;
  assign rdata0 = r_rdata0;
  assign rdata1 = r_rdata1;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench driving a LAT=1 and a LAT=3 arbiter,
// each backed by its own byte memory and an independent reference copy.
module tb_mem_arbiter;

  typedef struct {
    bit          port;
    bit          err;
    logic [31:0] rdata;
    logic [31:0] other;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_v, req0_v, req1_v, we1_v, ack0_v, ack1_v, err0_v, err1_v, mr_v, mw_v;
  logic [31:0] addr0_s[2], addr1_s[2], wdata1_s[2], rdata0_s[2], rdata1_s[2];
  logic [31:0] maddr_s[2], wd_s[2], rd_s[2];

  logic [7:0]  mem[2][1024];
  logic [7:0]  mdl[2][1024];
  logic [31:0] last[2][2];
  logic [31:0] cur_addr[2], cur_wd[2];
  int          rdc[2], wrc[2];
  int          lats[2] = '{1, 3};
  exp_t        q1[$];
  exp_t        q3[$];
  int          errors = 0;
  int          checks = 0;

  mem_arbiter #(.LAT(1), .DEPTH_BYTES(1024)) u_lat1 (
    .clk(clk), .rst(rst_v[0]),
    .req0(req0_v[0]), .addr0(addr0_s[0]), .ack0(ack0_v[0]), .err0(err0_v[0]), .rdata0(rdata0_s[0]),
    .req1(req1_v[0]), .we1(we1_v[0]), .addr1(addr1_s[0]), .wdata1(wdata1_s[0]),
    .ack1(ack1_v[0]), .err1(err1_v[0]), .rdata1(rdata1_s[0]),
    .MemRead(mr_v[0]), .MemWrite(mw_v[0]), .addr(maddr_s[0]), .wd(wd_s[0]), .rd(rd_s[0])
  );

  mem_arbiter #(.LAT(3), .DEPTH_BYTES(1024)) u_lat3 (
    .clk(clk), .rst(rst_v[1]),
    .req0(req0_v[1]), .addr0(addr0_s[1]), .ack0(ack0_v[1]), .err0(err0_v[1]), .rdata0(rdata0_s[1]),
    .req1(req1_v[1]), .we1(we1_v[1]), .addr1(addr1_s[1]), .wdata1(wdata1_s[1]),
    .ack1(ack1_v[1]), .err1(err1_v[1]), .rdata1(rdata1_s[1]),
    .MemRead(mr_v[1]), .MemWrite(mw_v[1]), .addr(maddr_s[1]), .wd(wd_s[1]), .rd(rd_s[1])
  );

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      rd_s[d] = {mem[d][int'(maddr_s[d][9:0]) + 3], mem[d][int'(maddr_s[d][9:0]) + 2],
                 mem[d][int'(maddr_s[d][9:0]) + 1], mem[d][int'(maddr_s[d][9:0])]};
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mw_v[d]) begin
        for (int b = 0; b < 4; b++) mem[d][int'(maddr_s[d][9:0]) + b] <= wd_s[d][8*b +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input int d, input logic [31:0] a);
    int i;
    i = int'(a[9:0]);
    return {mdl[d][i+3], mdl[d][i+2], mdl[d][i+1], mdl[d][i]};
  endfunction

  function automatic exp_t make_exp(input int d, input bit p, input bit we,
                                    input logic [31:0] a, input logic [31:0] wdv);
    exp_t x;
    bit   e;
    e       = (a[1:0] != 2'b00) || (a > 32'd1020);
    x.port  = p;
    x.err   = e;
    x.rdata = last[d][p];
    x.other = last[d][!p];
    if (!e && !we) x.rdata = word(d, a);
    if (!e && we) begin
      for (int b = 0; b < 4; b++) mdl[d][int'(a[9:0]) + b] = wdv[8*b +: 8];
    end
    last[d][p] = x.rdata;
    return x;
  endfunction

  task automatic push(input int d, input exp_t x);
    if (d == 0) q1.push_back(x);
    else q3.push_back(x);
  endtask

  task automatic mon(input int d);
    exp_t x;
    int   sz;
    if (mr_v[d]) rdc[d]++;
    if (mw_v[d]) begin
      wrc[d]++;
      check("wr_addr", maddr_s[d], cur_addr[d]);
      check("wr_data", wd_s[d], cur_wd[d]);
    end
    if (mr_v[d] || mw_v[d]) check("strobe_excl", 32'(mr_v[d] & mw_v[d]), 0);
    if (ack0_v[d] || ack1_v[d]) begin
      sz = (d == 0) ? q1.size() : q3.size();
      check("one_ack", 32'(ack0_v[d] & ack1_v[d]), 0);
      check("sb_nonempty", 32'(sz != 0), 1);
      if (sz != 0) begin
        if (d == 0) x = q1.pop_front();
        else x = q3.pop_front();
        check("ack_port", 32'(ack1_v[d]), 32'(x.port));
        check("err", 32'(x.port ? err1_v[d] : err0_v[d]), 32'(x.err));
        check("rdata", x.port ? rdata1_s[d] : rdata0_s[d], x.rdata);
        check("rdata_other", x.port ? rdata0_s[d] : rdata1_s[d], x.other);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic chk_idle(input int d, input string tag);
    check({tag, "_ack0"}, 32'(ack0_v[d]), 0);
    check({tag, "_ack1"}, 32'(ack1_v[d]), 0);
    check({tag, "_err0"}, 32'(err0_v[d]), 0);
    check({tag, "_err1"}, 32'(err1_v[d]), 0);
    check({tag, "_mr"}, 32'(mr_v[d]), 0);
    check({tag, "_mw"}, 32'(mw_v[d]), 0);
    check({tag, "_addr"}, maddr_s[d], 0);
    check({tag, "_wd"}, wd_s[d], 0);
    check({tag, "_rdata0"}, rdata0_s[d], 0);
    check({tag, "_rdata1"}, rdata1_s[d], 0);
  endtask

  // hold = number of edges after driving before the request is withdrawn.
  task automatic txn(input int d, input bit p, input bit we, input logic [31:0] a,
                     input logic [31:0] wdv, input int hold);
    exp_t x;
    int   n, rd0, wr0, lat_exp;
    bit   got;
    @(negedge clk);
    x = make_exp(d, p, we, a, wdv);
    push(d, x);
    lat_exp     = x.err ? 1 : lats[d] + 1;
    cur_addr[d] = a;
    cur_wd[d]   = wdv;
    rd0 = rdc[d];
    wr0 = wrc[d];
    if (p) begin
      req1_v[d] = 1'b1; we1_v[d] = we; addr1_s[d] = a; wdata1_s[d] = wdv;
    end else begin
      req0_v[d] = 1'b1; addr0_s[d] = a;
    end
    n   = 0;
    got = 1'b0;
    while (n < 20 && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        addr0_s[d] = 32'h0000_00FC; addr1_s[d] = 32'h0000_0030;
        wdata1_s[d] = 32'h1234_5678; we1_v[d] = ~we1_v[d];
      end
      if (n == hold) begin
        req0_v[d] = 1'b0; req1_v[d] = 1'b0;
      end
      got = p ? ack1_v[d] : ack0_v[d];
    end
    req0_v[d] = 1'b0;
    req1_v[d] = 1'b0;
    we1_v[d]  = 1'b0;
    check("latency", n, lat_exp);
    check("rd_strobes", rdc[d] - rd0, (!x.err && !we) ? lats[d] : 0);
    check("wr_strobes", wrc[d] - wr0, (!x.err && we) ? 1 : 0);
    @(negedge clk);
  endtask

  initial begin
    int   n, k, wr0;
    int   t[4];
    exp_t x;
    rst_v = 2'b11; req0_v = 2'b00; req1_v = 2'b00; we1_v = 2'b00;
    for (int d = 0; d < 2; d++) begin
      addr0_s[d] = 0; addr1_s[d] = 0; wdata1_s[d] = 0;
      cur_addr[d] = 0; cur_wd[d] = 0; rdc[d] = 0; wrc[d] = 0;
      last[d][0] = 0; last[d][1] = 0;
      for (int i = 0; i < 1024; i++) begin
        mem[d][i] <= 8'(i * 7 + 3);
        mdl[d][i] = 8'(i * 7 + 3);
      end
    end
    mem[0][16] <= 8'h44; mem[0][17] <= 8'h33; mem[0][18] <= 8'h22; mem[0][19] <= 8'h11;
    mdl[0][16] = 8'h44; mdl[0][17] = 8'h33; mdl[0][18] = 8'h22; mdl[0][19] = 8'h11;
    #2;
    chk_idle(0, "reset1");
    chk_idle(1, "reset3");
    repeat (2) @(negedge clk);
    rst_v = 2'b00;

    txn(0, 0, 0, 32'd16, 0, 1);
    check("word16", rdata0_s[0], 32'h1122_3344);
    txn(0, 1, 1, 32'd32, 32'hDEAD_BEEF, 1);
    txn(0, 1, 0, 32'd32, 0, 1);
    check("word32", rdata1_s[0], 32'hDEAD_BEEF);
    txn(0, 1, 0, 32'd6, 0, 1);
    txn(0, 1, 0, 32'd1024, 0, 1);
    txn(0, 1, 1, 32'd1021, 32'h0BAD_0BAD, 1);
    txn(0, 1, 0, 32'd1020, 0, 1);
    txn(0, 0, 0, 32'd2, 0, 1);
    txn(0, 0, 0, 32'd20, 0, 2);

    txn(1, 0, 0, 32'd40, 0, 1);
    txn(1, 1, 1, 32'd12, 32'hA5A5_0F0F, 1);
    txn(1, 1, 0, 32'd12, 0, 1);
    txn(1, 0, 0, 32'd100, 0, 3);
    txn(1, 1, 0, 32'd3, 0, 1);

    // Reset in the middle of a LAT=3 write must swallow the write.
    @(negedge clk);
    wr0 = wrc[1];
    req1_v[1] = 1'b1; we1_v[1] = 1'b1; addr1_s[1] = 32'd8; wdata1_s[1] = 32'hCAFE_F00D;
    cur_addr[1] = 32'd8; cur_wd[1] = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    req1_v[1] = 1'b0; we1_v[1] = 1'b0;
    @(posedge clk);
    #2;
    rst_v[1] = 1'b1;
    #1;
    chk_idle(1, "midrst");
    @(negedge clk);
    rst_v[1] = 1'b0;
    last[1][0] = 0; last[1][1] = 0;
    repeat (6) @(negedge clk);
    check("midrst_writes", wrc[1] - wr0, 0);
    check("midrst_mem", {mem[1][11], mem[1][10], mem[1][9], mem[1][8]}, word(1, 32'd8));

    // Round robin under continuous contention from a fresh reset.
    @(negedge clk);
    rst_v[0] = 1'b1;
    @(negedge clk);
    rst_v[0] = 1'b0;
    last[0][0] = 0; last[0][1] = 0;
    chk_idle(0, "rr_reset");
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      x = make_exp(0, i[0], 1'b0, i[0] ? 32'd4 : 32'd0, 0);
      push(0, x);
    end
    req0_v[0] = 1'b1; addr0_s[0] = 32'd0;
    req1_v[0] = 1'b1; addr1_s[0] = 32'd4; we1_v[0] = 1'b0;
    n = 0;
    k = 0;
    while (n < 40 && k < 4) begin
      @(posedge clk);
      #1;
      n++;
      if (ack0_v[0] || ack1_v[0]) begin
        t[k] = n;
        k++;
      end
    end
    req0_v[0] = 1'b0;
    req1_v[0] = 1'b0;
    check("rr_acks", k, 4);
    check("rr_first", t[0], 2);
    for (int i = 1; i < 4; i++) check("rr_gap", t[i] - t[i-1], 3);
    repeat (3) @(negedge clk);

    check("sb_drained", q1.size() + q3.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
